// File: rtl/regfile_mp_pkg.sv
// ---------------------------------------------------------------------------
// regfile_mp_pkg
//   Shared definitions for the multi-port register file:
//     - default DATA_W / ADDR_W / NUM_RD values used by regfile_mp;
//     - ZERO_IDX, the index of the optional hardwired zero register;
//     - port_lsb(), the packing helper that locates port i's slice inside
//       the flattened rd_addr / rd_data / register-array buses;
//     - rd_src_e, the selector naming where a read port sources its data.
// ---------------------------------------------------------------------------
package regfile_mp_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_NUM_RD = 2;

   // Register that reads as zero when the ZERO_REG option is enabled.
   localparam int ZERO_IDX = 0;

   // Where a read port takes its operand from.
   typedef enum logic [1:0] {
      SRC_ARRAY  = 2'd0,   // stored register contents, readiness from busy bit
      SRC_BYPASS = 2'd1,   // same-cycle writeback forwarded to the read
      SRC_ZERO   = 2'd2    // hardwired zero register
   } rd_src_e;

   // Low bit of element 'idx' in a bus of equal 'width'-bit elements,
   // element 0 in the least significant position.
   function automatic int port_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_mp_rf_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
//   One combinational read port of regfile_mp. Selects one register out of
//   the flattened array, applies the optional write bypass and the optional
//   hardwired zero register, and reports whether the operand is ready.
//
// Ports:
//   mem_flat  in  DEPTH*DATA_W  all registers, reg n = [n*DATA_W +: DATA_W]
//   busy_vec  in  DEPTH         scoreboard, bit n = reg n has a pending write
//   wr_en     in  1             writeback valid (bypass source)
//   wr_addr   in  ADDR_W        writeback destination
//   wr_data   in  DATA_W        writeback value
//   rd_addr   in  ADDR_W        register to read
//   rd_data   out DATA_W        operand value
//   rd_ready  out 1             operand valid (not pending, bypassed or zero)
// ---------------------------------------------------------------------------
module rf_read_port
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0,
   localparam int DEPTH   = 2 ** ADDR_W
) (
   input  logic [DEPTH*DATA_W-1:0] mem_flat,
   input  logic [DEPTH-1:0]        busy_vec,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_ready
);

   logic            is_zero;
   logic            bypass_hit;
   logic [DATA_W-1:0] stored;
   rd_src_e         src;

   assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_IDX));

   // The zero register takes priority: a write aimed at it is dropped by the
   // array, so forwarding it would expose a value that never lands.
   assign bypass_hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr) && !is_zero;

   assign stored = mem_flat[port_lsb(int'(rd_addr), DATA_W) +: DATA_W];

   always_comb begin
      src = SRC_ARRAY;
      if (is_zero) begin
         src = SRC_ZERO;
      end else if (bypass_hit) begin
         src = SRC_BYPASS;
      end
   end

   always_comb begin
      rd_data  = '0;
      rd_ready = 1'b1;
      case (src)
         SRC_ZERO: begin
            rd_data  = '0;
            rd_ready = 1'b1;
         end
         SRC_BYPASS: begin
            // The producer is completing this cycle, so the operand is valid
            // even if the busy bit is still set.
            rd_data  = wr_data;
            rd_ready = 1'b1;
         end
         default: begin
            rd_data  = stored;
            rd_ready = !busy_vec[rd_addr];
         end
      endcase
   end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised register file with NUM_RD combinational read ports and a
//   per-register pending-write scoreboard. Issue logic reserves a
//   destination (sets its busy bit); ALU writeback stores the result and
//   clears the busy bit.
//
//   Handshake semantics: wr_en and rsv_en are valid-only strobes with no
//   ready; the register file accepts every strobe on the rising edge where
//   it is high. rd_ready is an operand-valid indication towards issue, not
//   a flow-control ready: a read never stalls, it just reports whether the
//   value it returns is final.
//
// Ports:
//   clk       in  1              clock, all state updates on rising edge
//   rst_n     in  1              synchronous active-low reset
//   wr_en     in  1              writeback valid
//   wr_addr   in  ADDR_W         writeback destination
//   wr_data   in  DATA_W         writeback value
//   rsv_en    in  1              reserve a destination (mark busy)
//   rsv_addr  in  ADDR_W         register being reserved
//   rd_addr   in  NUM_RD*ADDR_W  packed read addresses, port i at i*ADDR_W
//   rd_data   out NUM_RD*DATA_W  packed read data, port i at i*DATA_W
//   rd_ready  out NUM_RD         per-port operand valid
//   busy_vec  out 2**ADDR_W      scoreboard, bit n = reg n pending
// ---------------------------------------------------------------------------
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0,
   localparam int DEPTH   = 2 ** ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   output logic [DEPTH-1:0]         busy_vec
);

   logic [DATA_W-1:0]       mem_q [DEPTH];
   logic [DEPTH*DATA_W-1:0] mem_flat;
   logic [DEPTH-1:0]        busy_q;
   logic [DEPTH-1:0]        busy_nxt;
   logic                    wr_ok;
   logic                    rsv_ok;

   // Accesses to the hardwired zero register are discarded here, so its
   // storage stays at its reset value and its busy bit never rises.
   assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(ZERO_IDX)));
   assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_IDX)));

   // Writeback clears first, reservation sets second: when both hit the same
   // register the new producer wins and the register stays busy.
   always_comb begin
      busy_nxt = busy_q;
      if (wr_ok) begin
         busy_nxt[wr_addr] = 1'b0;
      end
      if (rsv_ok) begin
         busy_nxt[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
         for (int n = 0; n < DEPTH; n++) begin
            mem_q[n] <= '0;
         end
      end else begin
         busy_q <= busy_nxt;
         if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
         end
      end
   end

   assign busy_vec = busy_q;

   for (genvar n = 0; n < DEPTH; n++) begin : g_flat
      assign mem_flat[port_lsb(n, DATA_W) +: DATA_W] = mem_q[n];
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .mem_flat (mem_flat),
         .busy_vec (busy_q),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rd_addr  (rd_addr[port_lsb(i, ADDR_W) +: ADDR_W]),
         .rd_data  (rd_data[port_lsb(i, DATA_W) +: DATA_W]),
         .rd_ready (rd_ready[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Two configurations side by side:
//     dut_a: 16-bit x 8, 2 read ports, BYPASS=1, ZERO_REG=0
//     dut_b: 32-bit x 16, 3 read ports, BYPASS=0, ZERO_REG=1
//   A behavioural model (plain arrays) tracks register contents and pending
//   bits; a negedge compare process checks every read port and busy_vec
//   against it each cycle. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int AD = 16, AA = 3, AN = 2;
   localparam int BD = 32, BA = 4, BN = 3;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT A signals ----------------
   logic             a_wr_en, a_rsv_en;
   logic [AA-1:0]    a_wr_addr, a_rsv_addr;
   logic [AD-1:0]    a_wr_data;
   logic [AN*AA-1:0] a_rd_addr;
   logic [AN*AD-1:0] a_rd_data;
   logic [AN-1:0]    a_rd_ready;
   logic [7:0]       a_busy_vec;

   // ---------------- DUT B signals ----------------
   logic             b_wr_en, b_rsv_en;
   logic [BA-1:0]    b_wr_addr, b_rsv_addr;
   logic [BD-1:0]    b_wr_data;
   logic [BN*BA-1:0] b_rd_addr;
   logic [BN*BD-1:0] b_rd_data;
   logic [BN-1:0]    b_rd_ready;
   logic [15:0]      b_busy_vec;

   regfile_mp #(.DATA_W(AD), .ADDR_W(AA), .NUM_RD(AN), .BYPASS(1), .ZERO_REG(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
      .busy_vec(a_busy_vec)
   );

   regfile_mp #(.DATA_W(BD), .ADDR_W(BA), .NUM_RD(BN), .BYPASS(0), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
      .busy_vec(b_busy_vec)
   );

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   int  n_cmp  = 0;
   int  n_bad  = 0;
   bit  chk_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [AD-1:0] ma [8];
   logic [7:0]    ma_busy;
   logic [BD-1:0] mb [16];
   logic [15:0]   mb_busy;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int n = 0; n < 8; n++) ma[n] = '0;
         for (int n = 0; n < 16; n++) mb[n] = '0;
         ma_busy = '0;
         mb_busy = '0;
      end else begin
         if (a_wr_en) begin
            ma[a_wr_addr]      = a_wr_data;
            ma_busy[a_wr_addr] = 1'b0;
         end
         if (a_rsv_en) ma_busy[a_rsv_addr] = 1'b1;
         if (b_wr_en && b_wr_addr != 0) begin
            mb[b_wr_addr]      = b_wr_data;
            mb_busy[b_wr_addr] = 1'b0;
         end
         if (b_rsv_en && b_rsv_addr != 0) mb_busy[b_rsv_addr] = 1'b1;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [AA-1:0] ra;
      logic [BA-1:0] rb;
      if (chk_on) begin
         for (int i = 0; i < AN; i++) begin
            ra = a_rd_addr[i*AA +: AA];
            if (a_wr_en && a_wr_addr == ra) begin
               exp_q.push_back(64'(a_wr_data));
               exp_q.push_back(64'(1));
            end else begin
               exp_q.push_back(64'(ma[ra]));
               exp_q.push_back(64'(!ma_busy[ra]));
            end
         end
         for (int i = 0; i < AN; i++) begin
            check($sformatf("a_rd_data[%0d]", i), 64'(a_rd_data[i*AD +: AD]), exp_q.pop_front());
            check($sformatf("a_rd_ready[%0d]", i), 64'(a_rd_ready[i]), exp_q.pop_front());
         end
         check("a_busy_vec", 64'(a_busy_vec), 64'(ma_busy));

         for (int i = 0; i < BN; i++) begin
            rb = b_rd_addr[i*BA +: BA];
            if (rb == 0) begin
               exp_q.push_back(64'(0));
               exp_q.push_back(64'(1));
            end else begin
               exp_q.push_back(64'(mb[rb]));
               exp_q.push_back(64'(!mb_busy[rb]));
            end
         end
         for (int i = 0; i < BN; i++) begin
            check($sformatf("b_rd_data[%0d]", i), 64'(b_rd_data[i*BD +: BD]), exp_q.pop_front());
            check($sformatf("b_rd_ready[%0d]", i), 64'(b_rd_ready[i]), exp_q.pop_front());
         end
         check("b_busy_vec", 64'(b_busy_vec), 64'(mb_busy));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic a_set(input logic we, input logic [AA-1:0] wa, input logic [AD-1:0] wd,
                        input logic re, input logic [AA-1:0] ra,
                        input logic [AA-1:0] r0, input logic [AA-1:0] r1);
      a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
      a_rsv_en = re; a_rsv_addr = ra;
      a_rd_addr = {r1, r0};
   endtask

   task automatic b_set(input logic we, input logic [BA-1:0] wa, input logic [BD-1:0] wd,
                        input logic re, input logic [BA-1:0] ra,
                        input logic [BA-1:0] r0, input logic [BA-1:0] r1, input logic [BA-1:0] r2);
      b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
      b_rsv_en = re; b_rsv_addr = ra;
      b_rd_addr = {r2, r1, r0};
   endtask

   task automatic idle_all();
      a_set(1'b0, '0, '0, 1'b0, '0, '0, '0);
      b_set(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic rand_all();
      a_set(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 3'($urandom));
      b_set(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_a_data"},  64'(a_rd_data),  64'(0));
      check({tag, "_a_ready"}, 64'(a_rd_ready), 64'(2'b11));
      check({tag, "_a_busy"},  64'(a_busy_vec), 64'(0));
      check({tag, "_b_data"},  64'(b_rd_data[63:0]), 64'(0));
      check({tag, "_b_ready"}, 64'(b_rd_ready), 64'(3'b111));
      check({tag, "_b_busy"},  64'(b_busy_vec), 64'(0));
   endtask

   function automatic logic [BD-1:0] bval(input int i);
      return 32'hA500_0000 | (32'(i) * 32'h0001_0203);
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      idle_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_on = 1'b1;
      #1;
      check_reset_state("reset");

      // Write then read, with bypass (A)
      a_set(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd5, 3'd5); #1;
      check("a_bypass_data", 64'(a_rd_data[15:0]), 64'h0000_BEEF);
      check("a_bypass_ready", 64'(a_rd_ready), 64'(2'b11));
      step(); a_set(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0); #1;
      check("a_write_read", 64'(a_rd_data[15:0]), 64'h0000_BEEF);

      // Write then read, without bypass (B): old value in the write cycle
      step(); b_set(1'b1, 4'd5, 32'h0000_BEEF, 1'b0, 4'd0, 4'd5, 4'd5, 4'd5); #1;
      check("b_no_bypass", 64'(b_rd_data[31:0]), 64'(0));
      step(); b_set(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd0, 4'd0); #1;
      check("b_write_read", 64'(b_rd_data[31:0]), 64'h0000_BEEF);

      // Scoreboard (A)
      step(); a_set(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd0, 3'd3); #1;
      check("a_rsv_same_cycle_ready", 64'(a_rd_ready[1]), 64'(1));
      step(); a_set(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd3); #1;
      check("a_rsv_busy", 64'(a_busy_vec), 64'h08);
      check("a_rsv_ready", 64'(a_rd_ready[1]), 64'(0));
      step(); a_set(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd3); #1;
      check("a_wb_bypass_data", 64'(a_rd_data[31:16]), 64'h1234);
      check("a_wb_bypass_ready", 64'(a_rd_ready[1]), 64'(1));
      step(); a_set(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd3); #1;
      check("a_wb_busy_clear", 64'(a_busy_vec), 64'h00);

      // Simultaneous events (A)
      step(); a_set(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 3'd2, 3'd2); #1;
      step(); a_set(1'b1, 3'd1, 16'h1111, 1'b1, 3'd6, 3'd2, 3'd1); #1;
      check("a_same_addr_busy", 64'(a_busy_vec), 64'h04);
      check("a_same_addr_data", 64'(a_rd_data[15:0]), 64'h00AA);
      check("a_same_addr_ready", 64'(a_rd_ready[0]), 64'(0));
      step(); a_set(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd6); #1;
      check("a_diff_addr_busy", 64'(a_busy_vec), 64'h44);
      check("a_diff_addr_data", 64'(a_rd_data[15:0]), 64'h1111);
      check("a_diff_addr_ready", 64'(a_rd_ready), 64'(2'b01));

      // Zero register (B)
      step(); b_set(1'b1, 4'd0, 32'h0000_FFFF, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0); #1;
      check("b_zero_wcycle_data", 64'(b_rd_data[31:0]), 64'(0));
      check("b_zero_wcycle_ready", 64'(b_rd_ready), 64'(3'b111));
      step(); b_set(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0); #1;
      check("b_zero_data", 64'(b_rd_data[31:0]), 64'(0));
      check("b_zero_ready", 64'(b_rd_ready), 64'(3'b111));
      check("b_zero_busy", 64'(b_busy_vec[0]), 64'(0));

      // Parametrisation: fill all 16 registers, read three per cycle
      for (int i = 0; i < 16; i++) begin
         step(); b_set(1'b1, 4'(i), bval(i), 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      end
      step(); idle_all();
      for (int k = 0; k < 6; k++) begin
         b_set(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(k), 4'(k + 5), 4'(k + 10)); #1;
         check("b_fill_p0", 64'(b_rd_data[31:0]),  (k == 0) ? 64'(0) : 64'(bval(k)));
         check("b_fill_p1", 64'(b_rd_data[63:32]), 64'(bval(k + 5)));
         check("b_fill_p2", 64'(b_rd_data[95:64]), 64'(bval(k + 10)));
         step();
      end
      b_set(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd15, 4'd15, 4'd15); #1;
      check("b_r15_p0", 64'(b_rd_data[31:0]),  64'(bval(15)));
      check("b_r15_p1", 64'(b_rd_data[63:32]), 64'(bval(15)));
      check("b_r15_p2", 64'(b_rd_data[95:64]), 64'(bval(15)));

      // Randomised traffic checked by the model
      for (int c = 0; c < 600; c++) begin
         step(); rand_all();
      end

      // Reset mid-operation, with traffic still present on the reset edge
      step(); rand_all(); rst_n = 1'b0;
      step(); idle_all(); rst_n = 1'b1; #1;
      check_reset_state("midreset");

      for (int c = 0; c < 200; c++) begin
         step(); rand_all();
      end

      step(); idle_all();
      step();
      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
